spi_master_lite: RTL and testbench

Single-slave SPI initiator (mode 0: CPOL=0, CPHA=0) that runs one fixed-length frame per request: shifts out a TX_W-bit command word on `mosi`, then clocks RX_W more bits and captures the slave's reply from `miso`. It sits between a simple valid/ready request port and an SPI peripheral on the SoC perip bus side, e.g. the bit-reversal slave (8 bits in, 8 bits reversed out). `ss` is driven active-low for exactly one frame.

---
 rtl/spi_master_lite.sv | 152 +++++++++++++++
 tb/tb_spi_master_lite.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_lite.sv
// Mode-0 SPI initiator: one TX_W-bit command then RX_W reply bits per request.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master_lite #(
    parameter int HALF_DIV = 2,
    parameter int TX_W     = 8,
    parameter int RX_W     = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [TX_W-1:0] tx_data,
    output logic            ready,
    output logic            rx_valid,
    output logic [RX_W-1:0] rx_data,
    output logic            sck,
    output logic            ss,
    output logic            mosi,
    input  logic            miso
);

    localparam int N     = TX_W + RX_W;
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int CNT_W = $clog2(N);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] IDX_LAST    = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] IDX_RX0     = CNT_W'(TX_W);
    localparam logic [CNT_W-1:0] IDX_TX_LAST = CNT_W'(TX_W - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [CNT_W-1:0]  bit_idx, bit_idx_n;
    logic [TX_W-1:0]   tx_sh, tx_sh_n;
    logic [RX_W-1:0]   rx_sh, rx_sh_n;
    logic              ready_n, rx_valid_n, sck_n, ss_n, mosi_n;
    logic [RX_W-1:0]   rx_data_n;
    logic              half_done;

    assign half_done = (div == DIV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            bit_idx  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            ready    <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            sck      <= 1'b0;
            ss       <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            state    <= state_n;
            div      <= div_n;
            bit_idx  <= bit_idx_n;
            tx_sh    <= tx_sh_n;
            rx_sh    <= rx_sh_n;
            ready    <= ready_n;
            rx_valid <= rx_valid_n;
            rx_data  <= rx_data_n;
            sck      <= sck_n;
            ss       <= ss_n;
            mosi     <= mosi_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = half_done ? '0 : div + DIV_W'(1);
        bit_idx_n  = bit_idx;
        tx_sh_n    = tx_sh;
        rx_sh_n    = rx_sh;
        ready_n    = ready;
        rx_valid_n = rx_valid;
        rx_data_n  = rx_data;
        sck_n      = sck;
        ss_n       = ss;
        mosi_n     = mosi;
        case (state)
            IDLE: begin
                div_n     = '0;
                bit_idx_n = '0;
                if (start && ready) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                    mosi_n  = tx_data[0];
                    tx_sh_n = tx_data >> 1;
`else
                    mosi_n  = tx_data[TX_W-1];
                    tx_sh_n = tx_data << 1;
`endif
                    ss_n    = 1'b0;
                    ready_n = 1'b0;
                    state_n = LEAD;
                end
            end
            LEAD, LOW: begin
                if (half_done) begin
                    sck_n   = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (half_done) begin
                    sck_n = 1'b0;
                    // Capture on the falling edge we generate, reply bits only.
                    if (bit_idx >= IDX_RX0) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
                        rx_sh_n = (rx_sh >> 1) | (RX_W'(miso) << (RX_W - 1));
`else
                        rx_sh_n = (rx_sh << 1) | RX_W'(miso);
`endif
                    end
                    if (bit_idx == IDX_LAST) begin
                        state_n = TRAIL;
                    end else begin
                        bit_idx_n = bit_idx + CNT_W'(1);
`ifdef SPI_MASTER_LSB_FIRST_EN
                        mosi_n  = (bit_idx < IDX_TX_LAST) ? tx_sh[0] : 1'b0;
                        tx_sh_n = tx_sh >> 1;
`else
                        mosi_n  = (bit_idx < IDX_TX_LAST) ? tx_sh[TX_W-1] : 1'b0;
                        tx_sh_n = tx_sh << 1;
`endif
                        state_n = LOW;
                    end
                end
            end
            TRAIL: begin
                if (half_done) begin
                    ss_n       = 1'b1;
                    mosi_n     = 1'b0;
                    rx_data_n  = rx_sh;
                    rx_valid_n = 1'b1;
                    state_n    = GAP;
                end
            end
            GAP: begin
                rx_valid_n = 1'b0;
                if (half_done) begin
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_lite.sv
// Directed bench for spi_master_lite with a bit-reversal slave model attached.
module tb_spi_master_lite;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = '0;
    logic       ready, rx_valid, sck, ss, mosi, miso;
    logic [7:0] rx_data;

    logic       start1 = 1'b0;
    logic [7:0] tx1 = '0;
    logic       ready1, rx_valid1, sck1, ss1, mosi1;
    logic [7:0] rx_data1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    spi_master_lite #(.HALF_DIV(2), .TX_W(8), .RX_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .tx_data(tx_data),
        .ready(ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    spi_master_lite #(.HALF_DIV(1), .TX_W(8), .RX_W(8)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .tx_data(tx1),
        .ready(ready1), .rx_valid(rx_valid1), .rx_data(rx_data1),
        .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(1'b1)
    );

    // Slave shifts mosi in on sck rise, then returns the word bit-reversed, MSB-first.
    logic [4:0] sl_cnt = '0;
    logic [7:0] sl_in  = '0;
    logic [2:0] sl_ridx;
    always @(posedge sck or posedge ss) begin
        if (ss) begin
            sl_cnt <= '0;
        end else begin
            sl_cnt <= sl_cnt + 5'd1;
            if (sl_cnt < 5'd8) sl_in <= {sl_in[6:0], mosi};
        end
    end
    assign sl_ridx = 3'(sl_cnt - 5'd9);
    assign miso = (!ss && sl_cnt >= 5'd9 && sl_cnt <= 5'd16) ? sl_in[sl_ridx] : 1'b0;

    int rises_total = 0;
    always @(posedge sck) if (!ss) rises_total++;

    int mosi1_high = 0;
    always @(posedge clock) if (!ss1 && mosi1) mosi1_high++;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] tx);
        int k;
        int snap;
        k = 0;
        while (!ready && k < 200) begin tick(); k++; end
        chk("ready_before", 32'(ready), 32'd1);
        start   = 1'b1;
        tx_data = tx;
        snap    = rises_total;
        chk("ss_cycle0", 32'(ss), 32'd1);
        tick();
        start   = 1'b0;
        tx_data = ~tx;
        k = 1;
        chk("ss_cycle1", 32'(ss), 32'd0);
        while (!rx_valid && k < 200) begin tick(); k++; end
        chk("rx_valid_cycle", 32'(k), 32'd67);
        chk("ss_at_valid", 32'(ss), 32'd1);
        chk("rx_data", 32'(rx_data), 32'(rev8(tx)));
        chk("sck_rises", 32'(rises_total - snap), 32'd16);
`ifdef SPI_MASTER_LSB_FIRST_EN
        chk("mosi_order", 32'(sl_in), 32'(rev8(tx)));
`else
        chk("mosi_order", 32'(sl_in), 32'(tx));
`endif
        tick(); k++;
        chk("rx_valid_pulse", 32'(rx_valid), 32'd0);
        while (!ready && k < 200) begin tick(); k++; end
        chk("ready_cycle", 32'(k), 32'd69);
    endtask

    initial begin
        int k;
        int prev_acc;
        int frames;
        int seen;
        logic [7:0] acc_tx;

        #1 reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_frame(8'h01);
        run_frame(8'h0F);
        run_frame(8'hA5);
        run_frame(8'h3C);

        // Back-to-back: start held, tx_data changes every cycle.
        start    = 1'b1;
        prev_acc = -1;
        frames   = 0;
        acc_tx   = '0;
        for (int c = 0; c < 300 && frames < 3; c++) begin
            if (rx_valid) begin
                chk("b2b_rx_data", 32'(rx_data), 32'(rev8(acc_tx)));
                frames++;
            end
            if (ready && frames < 3) begin
                if (prev_acc >= 0) chk("b2b_spacing", 32'(c - prev_acc), 32'd69);
                prev_acc = c;
                acc_tx   = tx_data;
            end
            tick();
            tx_data = 8'(c * 37 + 5);
        end
        start = 1'b0;
        chk("b2b_frames", 32'(frames), 32'd3);

        // Mid-frame asynchronous reset.
        while (!ready) tick();
        start   = 1'b1;
        tx_data = 8'hC3;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ss", 32'(ss), 32'd1);
        chk("mid_rst_sck", 32'(sck), 32'd0);
        chk("mid_rst_mosi", 32'(mosi), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
        tick();
        #2 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (rx_valid) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);
        run_frame(8'h12);

        // HALF_DIV=1 instance, miso tied high.
        start1 = 1'b1;
        tx1    = 8'h00;
        tick();
        start1 = 1'b0;
        k = 1;
        while (!rx_valid1 && k < 200) begin tick(); k++; end
        chk("hd1_valid_cycle", 32'(k), 32'd34);
        chk("hd1_rx_data", 32'(rx_data1), 32'hFF);
        chk("hd1_mosi_low", 32'(mosi1_high), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
